wshb_ram_slave: RTL and testbench
=================================

WSHB_RAM_SLAVE -- requirements
Module: wshb_ram_slave

Interface
REQ-001 Parameter DEPTH_WORDS, default 1024: number of 32-bit words stored; power of two, 16..65536.
REQ-002 Parameter BASE_ADDR, default 32'h0000_0000: byte address of word 0; aligned to 4*DEPTH_WORDS.
REQ-003 Parameter WAIT_STATES, default 1: cycles between first sampled request and its ack/err; range 1..15.
REQ-004 Port sys_clk, input, 1: single clock; all state changes on its rising edge.
REQ-005 Port sys_rst_n, input, 1: reset, asynchronous assertion, active-low.
REQ-006 Port wshb_ifs, wshb_if.slave (DATA_BYTES=4): Wishbone B4 responder, carrying cyc, stb, we, sel[3:0], adr[31:0] (byte address), dat_ms[31:0], cti[2:0], bte[1:0] in; dat_sm[31:0], ack, err, rty out; the interface's own clk/rst are unused.

Function
REQ-007 A request SHALL be cyc & stb sampled high; in-range means BASE_ADDR <= adr < BASE_ADDR + 4*DEPTH_WORDS; word index = (adr - BASE_ADDR) >> 2; adr[1:0] ignored.
REQ-008 FSM states SHALL be IDLE, WAIT, RESP, BURST.
REQ-009 IDLE -> WAIT on request; wait counter loaded with WAIT_STATES-1; WAIT -> RESP when counter reaches 0.
REQ-010 In RESP, exactly one of ack (in-range) or err (out-of-range) SHALL be high for one cycle; first ack lands WAIT_STATES+1 cycles after the request is first sampled.
REQ-011 Read: dat_sm SHALL hold the addressed word in the ack cycle; dat_sm SHALL be 0 in err cycles and otherwise unspecified but stable.
REQ-012 Write: on the ack cycle, byte lane i of the word SHALL take dat_ms[8i+7:8i] iff sel[i]; no write on err, abort, or sel=0.
REQ-013 Classic cycle (cti = 000 or 111, or bte != 00): RESP -> IDLE; a back-to-back request SHALL be re-timed from IDLE.
REQ-014 Incrementing linear burst (cti=010, bte=00, in range): RESP -> BURST; ack SHALL then be issued every cycle that stb is high, dat_sm following adr; the master advances adr by 4 per ack.
REQ-015 BURST: stb low for a cycle (master wait state) -> no ack, state held; cti=111 acked -> IDLE; cti changes to anything else -> IDLE after that ack.
REQ-016 Burst crossing the upper range bound SHALL get err on the first out-of-range beat and return to IDLE.
REQ-017 cyc deasserted in any state SHALL return to IDLE next cycle with no ack/err and no write (abort).
REQ-018 ack and err SHALL never be high while cyc is low, and never together; rty SHALL be constant 0.
REQ-019 The storage read SHALL be synchronous: the RAM address is presented one cycle before each ack, with next-word prefetch in BURST so that single-cycle beats hold.

Reset
REQ-020 sys_rst_n low SHALL asynchronously force state IDLE, ack=0, err=0, dat_sm=0, wait counter=0.
REQ-021 Memory contents SHALL NOT be reset or cleared.
REQ-022 Reset asserted mid-transaction SHALL drop ack/err immediately with no partial write; the first request after release SHALL follow REQ-009 timing.

Structure
REQ-023 Package wshb_pkg SHALL hold the cti/bte enum constants (CLASSIC=000, CONST=001, INCR=010, EOB=111; LINEAR=00) and the FSM state typedef.
REQ-024 Storage SHALL be one sub-module, wshb_ram_array: 1-port synchronous RAM with 4 byte enables, DEPTH_WORDS x 32, inferable to block RAM.
REQ-025 Target is 120-400 lines of RTL.

Verification
REQ-026 Classic write then read, WAIT_STATES=1: write 32'hDEAD_BEEF @ 0x10 sel=1111, then read 0x10 -> ack 2 cycles after stb, dat_sm=32'hDEAD_BEEF.
REQ-027 Byte-lane write: preload 0x20=32'h1122_3344, write 32'hAABB_CCDD sel=0101 -> read returns 32'h11BB_33DD.
REQ-028 Burst read of 8 words from 0x0 with cti=010 ... 111, continuous stb -> first ack at cycle 2, then 7 consecutive acks, data = preloaded pattern, then IDLE.
REQ-029 Burst with stb low 2 cycles after beat 3 -> no ack in those cycles, beats 4..8 correct and in order.
REQ-030 Out-of-range read at BASE_ADDR + 4*DEPTH_WORDS -> err at cycle 2, ack=0, dat_sm=0; burst from the last word -> ack then err.
REQ-031 cyc dropped during WAIT of a write, and sys_rst_n pulsed during BURST -> no ack/err, target word unchanged, next classic read returns its original value.

Source files
------------

// File: rtl/wshb_pkg.sv
// ---------------------------------------------------------------------------
// wshb_pkg -- shared Wishbone B4 constants and the RAM slave state type.
//   cti_e   : cycle type identifier codes (classic, constant, incrementing,
//             end-of-burst)
//   bte_e   : burst type extension codes (linear and wrap variants)
//   state_e : responder FSM states
// ---------------------------------------------------------------------------
package wshb_pkg;

  typedef enum logic [2:0] {
    CLASSIC = 3'b000,
    CONST   = 3'b001,
    INCR    = 3'b010,
    EOB     = 3'b111
  } cti_e;

  typedef enum logic [1:0] {
    LINEAR = 2'b00,
    WRAP4  = 2'b01,
    WRAP8  = 2'b10,
    WRAP16 = 2'b11
  } bte_e;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP,
    BURST
  } state_e;

endpackage

// File: rtl/wshb_if.sv
// ---------------------------------------------------------------------------
// wshb_if -- Wishbone B4 bus bundle.
//   clk, rst         : bus-level clock/reset, carried for masters only
//   cyc, stb, we     : cycle, strobe, write enable (master -> slave)
//   sel              : byte lane selects
//   adr              : byte address
//   dat_ms / dat_sm  : write data / read data
//   cti, bte         : cycle type identifier, burst type extension
//   ack, err, rty    : slave termination signals
// ---------------------------------------------------------------------------
interface wshb_if #(
  parameter int DATA_BYTES = 4
) (
  input logic clk,
  input logic rst
);

  logic                    cyc;
  logic                    stb;
  logic                    we;
  logic [DATA_BYTES-1:0]   sel;
  logic [31:0]             adr;
  logic [8*DATA_BYTES-1:0] dat_ms;
  logic [8*DATA_BYTES-1:0] dat_sm;
  logic [2:0]              cti;
  logic [1:0]              bte;
  logic                    ack;
  logic                    err;
  logic                    rty;

  modport master (
    input  clk, rst, dat_sm, ack, err, rty,
    output cyc, stb, we, sel, adr, dat_ms, cti, bte
  );

  modport slave (
    input  cyc, stb, we, sel, adr, dat_ms, cti, bte,
    output dat_sm, ack, err, rty
  );

endinterface

// File: rtl/wshb_ram_array.sv
// ---------------------------------------------------------------------------
// wshb_ram_array -- single-port synchronous RAM, 32-bit words, byte enables.
// Read-first: rdata carries the word stored at addr before any same-edge
// write. Written in the template block-RAM inference expects.
//   sys_clk : clock
//   addr    : word address
//   we      : write enable, qualified per lane by be
//   be      : byte lane enables
//   wdata   : write data
//   rdata   : registered read data
// ---------------------------------------------------------------------------
module wshb_ram_array #(
  parameter int DEPTH_WORDS = 1024
) (
  input  logic                           sys_clk,
  input  logic [$clog2(DEPTH_WORDS)-1:0] addr,
  input  logic                           we,
  input  logic [3:0]                     be,
  input  logic [31:0]                    wdata,
  output logic [31:0]                    rdata
);

  logic [31:0] mem [DEPTH_WORDS];

  // NOTE: the storage array and its output register have no reset; a reset
  // branch would keep the array out of block RAM, and contents must survive
  // a bus reset anyway.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge sys_clk) begin
    for (int i = 0; i < 4; i++) begin
      if (we && be[i]) begin
        mem[addr][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
    rdata <= mem[addr];
  end

endmodule

// File: rtl/wshb_ram_slave.sv
// ---------------------------------------------------------------------------
// wshb_ram_slave -- Wishbone B4 RAM responder with programmable wait states
// and incrementing linear burst support.
//   sys_clk   : clock
//   sys_rst_n : asynchronous active-low reset
//   wshb_ifs  : Wishbone slave port (32-bit data, byte address)
// A request waits WAIT_STATES cycles, then terminates with ack (in range)
// or err (out of range). An in-range INCR/LINEAR request continues in BURST
// with one ack per strobed cycle. Dropping cyc aborts without side effects.
// ---------------------------------------------------------------------------
module wshb_ram_slave
  import wshb_pkg::*;
#(
  parameter int          DEPTH_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int          WAIT_STATES = 1
) (
  input logic    sys_clk,
  input logic    sys_rst_n,
  wshb_if.slave  wshb_ifs
);

  localparam int AW = $clog2(DEPTH_WORDS);

  state_e        state;
  state_e        state_nx;
  logic [3:0]    wait_cnt;
  logic [3:0]    wait_cnt_nx;

  logic          req;
  logic          in_range;
  logic          incr_burst;
  logic          ack;
  logic          err;
  logic          ram_we;
  logic [AW-1:0] word_idx;
  logic [AW-1:0] ram_addr;
  logic [31:0]   ram_rdata;
  logic          unused_adr_lsb;

  assign req        = wshb_ifs.cyc & wshb_ifs.stb;
  // BASE_ADDR is aligned to the window size, so range membership reduces to
  // matching the address bits above the window.
  assign in_range   = (wshb_ifs.adr[31:AW+2] == BASE_ADDR[31:AW+2]);
  assign word_idx   = wshb_ifs.adr[AW+1:2];
  assign incr_burst = (wshb_ifs.cti == INCR) && (wshb_ifs.bte == LINEAR);
  // Byte offset within a word plays no part in word addressing.
  assign unused_adr_lsb = ^wshb_ifs.adr[1:0];

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state    <= IDLE;
      wait_cnt <= '0;
    end else begin
      state    <= state_nx;
      wait_cnt <= wait_cnt_nx;
    end
  end

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can
    // leave a value unassigned and infer a latch.
    state_nx    = state;
    wait_cnt_nx = wait_cnt;
    ack         = 1'b0;
    err         = 1'b0;

    unique case (state)
      IDLE: begin
        if (req) begin
          state_nx    = WAIT;
          wait_cnt_nx = 4'(WAIT_STATES - 1);
        end
      end

      WAIT: begin
        if (!wshb_ifs.cyc) begin
          state_nx = IDLE;
        end else if (wait_cnt == '0) begin
          state_nx = RESP;
        end else begin
          wait_cnt_nx = wait_cnt - 4'd1;
        end
      end

      // RESP terminates the first beat; BURST terminates each later beat
      // with no wait states. Both hold while the master stalls stb low.
      RESP, BURST: begin
        if (!wshb_ifs.cyc) begin
          state_nx = IDLE;
        end else if (wshb_ifs.stb) begin
          ack      = in_range;
          err      = !in_range;
          state_nx = (in_range && incr_burst) ? BURST : IDLE;
        end
      end
    endcase
  end

  // The master advances adr on every ack, so a read ack prefetches the next
  // word; the following beat then finds its data already registered. A
  // write ack must address the current word instead.
  assign ram_we   = ack & wshb_ifs.we;
  assign ram_addr = (ack && !wshb_ifs.we) ? word_idx + AW'(1) : word_idx;

  wshb_ram_array #(
    .DEPTH_WORDS (DEPTH_WORDS)
  ) u_ram (
    .sys_clk (sys_clk),
    .addr    (ram_addr),
    .we      (ram_we),
    .be      (wshb_ifs.sel),
    .wdata   (wshb_ifs.dat_ms),
    .rdata   (ram_rdata)
  );

  // Read data is gated by ack: zero in err cycles, in reset and when idle.
  assign wshb_ifs.ack    = ack;
  assign wshb_ifs.err    = err;
  assign wshb_ifs.rty    = 1'b0;
  assign wshb_ifs.dat_sm = ack ? ram_rdata : '0;

endmodule

// File: tb/tb_wshb_ram_slave.sv
// ---------------------------------------------------------------------------
// tb_wshb_ram_slave -- scoreboard bench for wshb_ram_slave.
// Driver tasks issue classic and burst transactions, pushing the expected
// termination of each beat into a queue; a negedge monitor pops and checks
// every ack/err the DUT presents. A word-array memory model supplies the
// expected read data.
// ---------------------------------------------------------------------------
module tb_wshb_ram_slave;
  import wshb_pkg::*;

  localparam int          DEPTH = 64;
  localparam logic [31:0] BASE  = 32'h0000_0000;
  localparam int          WS    = 1;
  localparam logic [31:0] SPAN  = 32'(4 * DEPTH);

  typedef struct {
    bit          is_err;
    bit          is_rd;
    logic [31:0] data;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic bus_rst;
  assign bus_rst = ~rst_n;

  wshb_if #(.DATA_BYTES(4)) bus (.clk(clk), .rst(bus_rst));

  wshb_ram_slave #(
    .DEPTH_WORDS (DEPTH),
    .BASE_ADDR   (BASE),
    .WAIT_STATES (WS)
  ) dut (
    .sys_clk   (clk),
    .sys_rst_n (rst_n),
    .wshb_ifs  (bus)
  );

  always #5 clk = ~clk;

  int          total = 0;
  int          bad   = 0;
  logic [31:0] mem_m [DEPTH];
  exp_t        q [$];
  exp_t        mon_e;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", name, got, want, $time);
    end
  endtask

  function automatic bit in_rng(input logic [31:0] a);
    return (a >= BASE) && (a < BASE + SPAN);
  endfunction

  // Reference behaviour of one beat: out of range -> err; write -> merge
  // selected lanes into the model; read -> current model word.
  function automatic void expect_beat(input bit we, input logic [31:0] a,
                                      input logic [31:0] d, input logic [3:0] s);
    exp_t e;
    int   idx;
    e.is_err = 1'b0;
    e.is_rd  = 1'b0;
    e.data   = '0;
    if (!in_rng(a)) begin
      e.is_err = 1'b1;
    end else begin
      idx = int'((a - BASE) / 4);
      if (we) begin
        for (int i = 0; i < 4; i++)
          if (s[i]) mem_m[idx][8*i +: 8] = d[8*i +: 8];
      end else begin
        e.is_rd = 1'b1;
        e.data  = mem_m[idx];
      end
    end
    q.push_back(e);
  endfunction

  // Monitor: every termination the DUT presents must match the next
  // expectation, obey cyc, and never combine ack with err.
  always @(negedge clk) begin
    if (rst_n && (bus.ack || bus.err)) begin
      check("resp_needs_cyc", 32'(bus.cyc), 32'd1);
      check("ack_err_excl", 32'(bus.ack & bus.err), 32'd0);
      check("rty_zero", 32'(bus.rty), 32'd0);
      if (q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_resp: got ack=%0b err=%0b want none at %0t",
                 bus.ack, bus.err, $time);
      end else begin
        mon_e = q.pop_front();
        check("resp_is_err", 32'(bus.err), 32'(mon_e.is_err));
        if (mon_e.is_err)     check("err_dat_zero", bus.dat_sm, 32'd0);
        else if (mon_e.is_rd) check("rd_data", bus.dat_sm, mon_e.data);
      end
    end
  end

  task automatic idle_bus();
    bus.cyc    = 1'b0;
    bus.stb    = 1'b0;
    bus.we     = 1'b0;
    bus.sel    = '0;
    bus.adr    = '0;
    bus.dat_ms = '0;
    bus.cti    = CLASSIC;
    bus.bte    = LINEAR;
  endtask

  // Waits for a termination; n = negedges without one before it appeared.
  // Returns just after the edge that completes the handshake.
  task automatic wait_resp(output int n, output bit got);
    n   = 0;
    got = 1'b0;
    while (!got && n < 32) begin
      @(negedge clk);
      if (bus.ack || bus.err) got = 1'b1;
      else n++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic timeout_fail(input string name);
    total++;
    bad++;
    $display("FAIL %s: got no ack/err within 32 cycles want ack or err", name);
    q.delete();
  endtask

  task automatic classic(input bit we, input logic [31:0] a,
                         input logic [31:0] d, input logic [3:0] s);
    int n;
    bit got;
    int k;
    k          = int'($urandom_range(0, 2));
    bus.cyc    = 1'b1;
    bus.stb    = 1'b1;
    bus.we     = we;
    bus.adr    = a;
    bus.dat_ms = d;
    bus.sel    = s;
    // INCR with a non-linear bte is still a single-beat cycle.
    bus.cti    = (k == 0) ? CLASSIC : (k == 1) ? EOB : INCR;
    bus.bte    = (k == 2) ? WRAP4 : LINEAR;
    expect_beat(we, a, d, s);
    wait_resp(n, got);
    if (!got) timeout_fail("classic_timeout");
    else check("classic_latency", 32'(n), 32'(WS + 1));
    idle_bus();
  endtask

  task automatic burst(input bit we, input logic [31:0] a0, input int nb,
                       input int stall_after, input int stall_len);
    logic [31:0] d [8];
    logic [3:0]  s [8];
    int          n_eff;
    int          beat;
    int          n;
    bit          got;
    n_eff = nb;
    for (int i = 0; i < nb; i++) begin
      d[i] = $urandom;
      s[i] = we ? 4'($urandom) : 4'hF;
    end
    for (int i = 0; i < nb; i++) begin
      expect_beat(we, a0 + 32'(4 * i), d[i], s[i]);
      if (!in_rng(a0 + 32'(4 * i))) begin
        n_eff = i + 1;
        break;
      end
    end
    bus.cyc = 1'b1;
    bus.stb = 1'b1;
    bus.we  = we;
    bus.bte = LINEAR;
    beat    = 0;
    bus.adr    = a0;
    bus.dat_ms = d[0];
    bus.sel    = s[0];
    bus.cti    = (nb == 1) ? EOB : INCR;
    while (beat < n_eff) begin
      wait_resp(n, got);
      if (!got) begin
        timeout_fail("burst_timeout");
        break;
      end
      if (beat == 0) check("burst_first_latency", 32'(n), 32'(WS + 1));
      else           check("burst_beat_latency", 32'(n), 32'd0);
      beat++;
      if (beat < n_eff) begin
        bus.adr    = a0 + 32'(4 * beat);
        bus.dat_ms = d[beat];
        bus.sel    = s[beat];
        bus.cti    = (beat == nb - 1) ? EOB : INCR;
        if (beat == stall_after) begin
          bus.stb = 1'b0;
          repeat (stall_len) begin
            @(negedge clk);
            check("stall_no_resp", 32'(bus.ack | bus.err), 32'd0);
            @(posedge clk);
            #1;
          end
          bus.stb = 1'b1;
        end
      end
    end
    idle_bus();
  endtask

  // Starts a write and drops cyc while it is still waiting.
  task automatic abort_write(input logic [31:0] a);
    bus.cyc    = 1'b1;
    bus.stb    = 1'b1;
    bus.we     = 1'b1;
    bus.adr    = a;
    bus.dat_ms = ~mem_m[(a - BASE) / 4];
    bus.sel    = 4'hF;
    bus.cti    = CLASSIC;
    @(posedge clk);
    #1;
    bus.cyc = 1'b0;
    bus.stb = 1'b0;
    repeat (WS + 2) begin
      @(negedge clk);
      check("abort_no_resp", 32'(bus.ack | bus.err), 32'd0);
    end
    @(posedge clk);
    #1;
    idle_bus();
  endtask

  // Write burst interrupted by reset after two beats; beat 2 must not land.
  task automatic reset_in_burst(input logic [31:0] a0);
    logic [31:0] d [3];
    int          n;
    bit          got;
    for (int i = 0; i < 3; i++) d[i] = $urandom;
    expect_beat(1'b1, a0, d[0], 4'hF);
    expect_beat(1'b1, a0 + 32'd4, d[1], 4'hF);
    bus.cyc = 1'b1;
    bus.stb = 1'b1;
    bus.we  = 1'b1;
    bus.sel = 4'hF;
    bus.cti = INCR;
    bus.bte = LINEAR;
    for (int i = 0; i < 3; i++) begin
      bus.adr    = a0 + 32'(4 * i);
      bus.dat_ms = d[i];
      if (i < 2) begin
        wait_resp(n, got);
        check("rst_burst_beat_acked", 32'(got), 32'd1);
      end
    end
    #1;
    rst_n = 1'b0;
    @(negedge clk);
    check("rst_mid_ack", 32'(bus.ack), 32'd0);
    check("rst_mid_err", 32'(bus.err), 32'd0);
    check("rst_mid_dat", bus.dat_sm, 32'd0);
    @(posedge clk);
    #1;
    idle_bus();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish want finish before 500000 ns");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a;
    int          kind;
    idle_bus();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_ack", 32'(bus.ack), 32'd0);
    check("reset_err", 32'(bus.err), 32'd0);
    check("reset_dat", bus.dat_sm, 32'd0);
    check("reset_rty", 32'(bus.rty), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Preload every word so later reads have defined expectations.
    for (int i = 0; i < DEPTH; i++) classic(1'b1, BASE + 32'(4 * i), $urandom, 4'hF);

    classic(1'b1, BASE + 32'h10, 32'hDEAD_BEEF, 4'hF);
    classic(1'b0, BASE + 32'h10, 32'h0, 4'hF);

    classic(1'b1, BASE + 32'h20, 32'h1122_3344, 4'hF);
    classic(1'b1, BASE + 32'h20, 32'hAABB_CCDD, 4'b0101);
    classic(1'b0, BASE + 32'h20, 32'h0, 4'hF);
    classic(1'b1, BASE + 32'h24, 32'h5555_AAAA, 4'b0000);
    classic(1'b0, BASE + 32'h24, 32'h0, 4'hF);

    burst(1'b0, BASE, 8, -1, 0);
    burst(1'b0, BASE, 8, 3, 2);

    classic(1'b0, BASE + SPAN, 32'h0, 4'hF);
    burst(1'b0, BASE + SPAN - 32'd4, 4, -1, 0);
    burst(1'b1, BASE + SPAN - 32'd8, 4, -1, 0);

    abort_write(BASE + 32'h30);
    classic(1'b0, BASE + 32'h30, 32'h0, 4'hF);

    reset_in_burst(BASE + 32'h40);
    classic(1'b0, BASE + 32'h40, 32'h0, 4'hF);
    classic(1'b0, BASE + 32'h44, 32'h0, 4'hF);
    classic(1'b0, BASE + 32'h48, 32'h0, 4'hF);

    for (int t = 0; t < 200; t++) begin
      kind = int'($urandom_range(0, 9));
      if (kind < 4) begin
        a = BASE + 32'(4 * $urandom_range(0, DEPTH - 1)) + 32'($urandom_range(0, 3));
        classic(1'($urandom), a, $urandom, 4'($urandom));
      end else if (kind == 4) begin
        a = BASE + SPAN + 32'(4 * $urandom_range(0, 1000));
        classic(1'($urandom), a, $urandom, 4'hF);
      end else begin
        a = BASE + 32'(4 * $urandom_range(0, DEPTH - 1));
        burst(1'($urandom), a, int'($urandom_range(1, 8)),
              int'($urandom_range(1, 8)), int'($urandom_range(0, 3)));
      end
    end

    repeat (3) @(posedge clk);
    check("scoreboard_drained", 32'(q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
